// File: rtl/wave_snapshot_buffer_pkg.sv
// -----------------------------------------------------------------------------
// wave_snapshot_buffer_pkg
// Shared widths, FSM state encodings and helpers for the wave snapshot buffer
// (the upstream feeder of the bytes-screen UART streamer).
// -----------------------------------------------------------------------------
package wave_snapshot_buffer_pkg;

    localparam int NUM_OSCILLATORS = 4;
    localparam int WW_WIDTH        = 18;
    localparam int SAMPLE_WIDTH    = 16;

    typedef logic [2:0] snap_state_t;

    localparam snap_state_t ST_IDLE  = 3'd0;
    localparam snap_state_t ST_LATCH = 3'd1;
    localparam snap_state_t ST_REQ   = 3'd2;
    localparam snap_state_t ST_COPY  = 3'd3;
    localparam snap_state_t ST_DRAIN = 3'd4;
    localparam snap_state_t ST_SWAP  = 3'd5;

    // Limits a requested wave width to the number of samples one bank holds.
    function automatic logic [WW_WIDTH-1:0] clampWidth(input logic [WW_WIDTH-1:0] width,
                                                       input int unsigned depth);
        logic [31:0] wideWidth;
        logic [31:0] wideDepth;
        wideWidth = {{(32-WW_WIDTH){1'b0}}, width};
        wideDepth = depth;
        if (wideWidth > wideDepth)
            return wideDepth[WW_WIDTH-1:0];
        return width;
    endfunction

endpackage

// File: rtl/wave_snapshot_buffer_if.sv
// -----------------------------------------------------------------------------
// wave_snapshot_buffer_if
// Shared sample memory read port.
//   mem_req_out  : read port request
//   mem_gnt_in   : grant; an address is accepted only in a granted cycle
//   mem_addr_out : sample read address
//   mem_data_in  : read data, fixed pipelined latency after address acceptance
// master = snapshot buffer side, slave = memory / arbiter side.
// -----------------------------------------------------------------------------
interface wave_snapshot_buffer_if;
    import wave_snapshot_buffer_pkg::*;

    logic                    mem_req_out;
    logic                    mem_gnt_in;
    logic [WW_WIDTH-1:0]     mem_addr_out;
    logic [SAMPLE_WIDTH-1:0] mem_data_in;

    modport master (
        output mem_req_out,
        output mem_addr_out,
        input  mem_gnt_in,
        input  mem_data_in
    );

    modport slave (
        input  mem_req_out,
        input  mem_addr_out,
        output mem_gnt_in,
        output mem_data_in
    );

endinterface

// File: rtl/wave_snapshot_buffer_bank_ram.sv
// -----------------------------------------------------------------------------
// snapshot_bank_ram
// Simple dual-port block RAM: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
//   clk_in   : clock
//   i_wrEn   : write enable
//   i_wrAddr : write address {bank, offset}
//   i_wrData : write data
//   i_rdAddr : read address {bank, offset}
//   o_rdData : read data, one cycle after i_rdAddr
// No reset: contents are undefined after power-up.
// -----------------------------------------------------------------------------
module snapshot_bank_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk_in,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdData;

    always_ff @(posedge clk_in) begin
        if (i_wrEn)
            r_mem[i_wrAddr] <= i_wrData;
        r_rdData <= r_mem[i_rdAddr];
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/wave_snapshot_buffer.sv
// -----------------------------------------------------------------------------
// wave_snapshot_buffer
// On a frame request, copies wave_width samples from the shared sample memory
// into the write bank of a ping-pong buffer, latching the wave width and the
// oscillator indices at the same instant, then publishes the bank to the
// streamer once it is not mid-frame.
//   clk_in / rst_n_in      : clock, asynchronous active-low reset
//   frame_start_in         : 1-cycle snapshot request (ignored while busy)
//   reader_lock_in         : streamer mid-frame, defers the bank swap
//   wave_width_in          : current wave length in samples
//   osc_indices_in         : current playback index per oscillator
//   mem_if                 : shared sample memory read port (master)
//   snap_index_in          : streamer sample index
//   snap_data_out          : sample at snap_index_in, 1-cycle latency, 0 past width
//   snap_wave_width_out    : published width (post-clamp)
//   snap_osc_indices_out   : published oscillator indices
//   snap_valid_out         : a snapshot has been published since reset
//   snap_clamped_out       : published snapshot was truncated to BUF_DEPTH
//   busy_out               : capture in progress
//   done_out               : 1-cycle pulse on publish
// -----------------------------------------------------------------------------
module wave_snapshot_buffer
    import wave_snapshot_buffer_pkg::*;
#(
    parameter int BUF_DEPTH    = 8192,
    parameter int READ_LATENCY = 2
) (
    input  logic                                       clk_in,
    input  logic                                       rst_n_in,
    input  logic                                       frame_start_in,
    input  logic                                       reader_lock_in,
    input  logic [WW_WIDTH-1:0]                        wave_width_in,
    input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]   osc_indices_in,
    wave_snapshot_buffer_if.master                     mem_if,
    input  logic [WW_WIDTH-1:0]                        snap_index_in,
    output logic [SAMPLE_WIDTH-1:0]                    snap_data_out,
    output logic [WW_WIDTH-1:0]                        snap_wave_width_out,
    output logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]   snap_osc_indices_out,
    output logic                                       snap_valid_out,
    output logic                                       snap_clamped_out,
    output logic                                       busy_out,
    output logic                                       done_out
);

    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam logic [WW_WIDTH-1:0] ONE = 1;

    snap_state_t                               r_state;
    logic [WW_WIDTH-1:0]                       r_shadowWidth;
    logic                                      r_shadowClamp;
    logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]  r_shadowOsc;
    logic [WW_WIDTH-1:0]                       r_issueCnt;
    logic [WW_WIDTH-1:0]                       r_writeCnt;
    logic [READ_LATENCY-1:0]                   r_validPipe;
    logic                                      r_rdBank;
    logic [WW_WIDTH-1:0]                       r_snapWidth;
    logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]  r_snapOsc;
    logic                                      r_snapValid;
    logic                                      r_snapClamped;
    logic                                      r_done;
    logic                                      r_inRange;

    logic                                      w_reqActive;
    logic                                      w_issue;
    logic                                      w_lastIssue;
    logic                                      w_retValid;
    logic [WW_WIDTH-1:0]                       w_latchWidth;
    logic [SAMPLE_WIDTH-1:0]                   w_ramData;

    assign w_reqActive  = (r_state == ST_REQ) || (r_state == ST_COPY);
    assign w_issue      = w_reqActive && mem_if.mem_gnt_in;
    assign w_lastIssue  = w_issue && (r_issueCnt == (r_shadowWidth - ONE));
    assign w_retValid   = r_validPipe[READ_LATENCY-1];
    assign w_latchWidth = clampWidth(wave_width_in, BUF_DEPTH);

    // REQ and COPY share the address counter, so address 0 is what REQ presents.
    assign mem_if.mem_req_out  = w_reqActive;
    assign mem_if.mem_addr_out = w_reqActive ? r_issueCnt : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_IDLE;
            r_shadowWidth <= '0;
            r_shadowClamp <= 1'b0;
            r_shadowOsc   <= '0;
            r_issueCnt    <= '0;
            r_writeCnt    <= '0;
            r_validPipe   <= '0;
            r_rdBank      <= 1'b0;
            r_snapWidth   <= '0;
            r_snapOsc     <= '0;
            r_snapValid   <= 1'b0;
            r_snapClamped <= 1'b0;
            r_done        <= 1'b0;
            r_inRange     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // One bit per accepted address, aligned with its data return.
            r_validPipe[0] <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++)
                r_validPipe[i] <= r_validPipe[i-1];

            if (w_retValid)
                r_writeCnt <= r_writeCnt + ONE;

            r_inRange <= (snap_index_in < r_snapWidth);

            case (r_state)
                ST_IDLE: begin
                    if (frame_start_in)
                        r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_shadowWidth <= w_latchWidth;
                    r_shadowClamp <= (w_latchWidth != wave_width_in);
                    r_shadowOsc   <= osc_indices_in;
                    r_issueCnt    <= '0;
                    r_writeCnt    <= '0;
                    r_state       <= (w_latchWidth == '0) ? ST_SWAP : ST_REQ;
                end
                ST_REQ, ST_COPY: begin
                    if (w_issue) begin
                        r_issueCnt <= r_issueCnt + ONE;
                        r_state    <= w_lastIssue ? ST_DRAIN : ST_COPY;
                    end
                end
                ST_DRAIN: begin
                    // Count the return landing this cycle so SWAP follows the last write.
                    if ((r_writeCnt + WW_WIDTH'(w_retValid)) == r_shadowWidth)
                        r_state <= ST_SWAP;
                end
                ST_SWAP: begin
                    if (!reader_lock_in) begin
                        r_rdBank      <= ~r_rdBank;
                        r_snapWidth   <= r_shadowWidth;
                        r_snapOsc     <= r_shadowOsc;
                        r_snapClamped <= r_shadowClamp;
                        r_snapValid   <= 1'b1;
                        r_done        <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    snapshot_bank_ram #(
        .ADDR_W (IDX_W + 1),
        .DATA_W (SAMPLE_WIDTH)
    ) u_bankRam (
        .clk_in   (clk_in),
        .i_wrEn   (w_retValid),
        .i_wrAddr ({~r_rdBank, r_writeCnt[IDX_W-1:0]}),
        .i_wrData (mem_if.mem_data_in),
        .i_rdAddr ({r_rdBank, snap_index_in[IDX_W-1:0]}),
        .o_rdData (w_ramData)
    );

    assign snap_data_out        = r_inRange ? w_ramData : '0;
    assign snap_wave_width_out  = r_snapWidth;
    assign snap_osc_indices_out = r_snapOsc;
    assign snap_valid_out       = r_snapValid;
    assign snap_clamped_out     = r_snapClamped;
    assign busy_out             = (r_state != ST_IDLE);
    assign done_out             = r_done;

endmodule

// File: tb/tb_wave_snapshot_buffer.sv
// -----------------------------------------------------------------------------
// tb_wave_snapshot_buffer
// Drives wave_snapshot_buffer with a modelled 2-cycle pipelined sample memory
// and grant patterns, and compares the published snapshot with a reference
// built directly from the memory contents at request time.
// -----------------------------------------------------------------------------
module tb_wave_snapshot_buffer;

    localparam int DEPTH = 8192;

    typedef struct {
        int          width;
        int          gntMode;
        logic [15:0] base;
        int          expWidth;
        bit          expClamp;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              frameStart;
    logic              readerLock;
    logic [17:0]       waveWidth;
    logic [3:0][17:0]  oscIdx;
    logic [17:0]       snapIndex;
    logic [15:0]       snapData;
    logic [17:0]       snapWidth;
    logic [3:0][17:0]  snapOsc;
    logic              snapValid;
    logic              snapClamped;
    logic              busy;
    logic              done;

    wave_snapshot_buffer_if memIf ();

    wave_snapshot_buffer dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .frame_start_in       (frameStart),
        .reader_lock_in       (readerLock),
        .wave_width_in        (waveWidth),
        .osc_indices_in       (oscIdx),
        .mem_if               (memIf.master),
        .snap_index_in        (snapIndex),
        .snap_data_out        (snapData),
        .snap_wave_width_out  (snapWidth),
        .snap_osc_indices_out (snapOsc),
        .snap_valid_out       (snapValid),
        .snap_clamped_out     (snapClamped),
        .busy_out             (busy),
        .done_out             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]      memArr [DEPTH];
    logic [17:0]      addrD1;
    logic [17:0]      addrD2;
    int               gntMode;
    logic [17:0]      issuedQ [$];
    int               doneCnt;
    int               reqCnt;
    int               doneBefore;
    int               checkCount;
    int               passCount;
    int               modelWidth;
    bit               modelClamp;
    logic [3:0][17:0] modelOsc;
    logic [15:0]      modelBank [DEPTH];

    // Sample memory: data appears two cycles after the address.
    always @(posedge clk) begin
        addrD1 <= memIf.mem_addr_out;
        addrD2 <= addrD1;
    end
    assign memIf.mem_data_in = memArr[addrD2[12:0]];

    initial begin
        memIf.mem_gnt_in = 1'b1;
        forever begin
            @(negedge clk);
            case (gntMode)
                0:       memIf.mem_gnt_in = 1'b1;
                1:       memIf.mem_gnt_in = ~memIf.mem_gnt_in;
                default: memIf.mem_gnt_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n && memIf.mem_req_out && memIf.mem_gnt_in)
            issuedQ.push_back(memIf.mem_addr_out);
        if (memIf.mem_req_out)
            reqCnt <= reqCnt + 1;
        if (done)
            doneCnt <= doneCnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        else
            passCount++;
    endtask

    function automatic logic [15:0] expectedSample(input int idx);
        if (idx < modelWidth)
            return modelBank[idx];
        return 16'h0000;
    endfunction

    task automatic checkRead(input int idx);
        snapIndex = 18'(idx);
        @(negedge clk);
        checkOutput($sformatf("read[%0d]", idx), snapData, expectedSample(idx));
    endtask

    // Loads memory, builds the reference snapshot and pulses the request.
    // The width/index inputs are scrambled once they should have been latched.
    task automatic startCapture(input int width, input int mode, input logic [15:0] base, input bit randomMem);
        for (int i = 0; i < DEPTH; i++)
            memArr[i] = randomMem ? 16'($urandom) : base + 16'(i);
        modelWidth = (width > DEPTH) ? DEPTH : width;
        modelClamp = (width > DEPTH);
        for (int o = 0; o < 4; o++)
            modelOsc[o] = 18'($urandom);
        for (int i = 0; i < modelWidth; i++)
            modelBank[i] = memArr[i];
        gntMode = mode;
        issuedQ.delete();
        doneBefore = doneCnt;
        @(negedge clk);
        waveWidth  = 18'(width);
        oscIdx     = modelOsc;
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        @(negedge clk);
        waveWidth = 18'($urandom);
        for (int o = 0; o < 4; o++)
            oscIdx[o] = 18'($urandom);
    endtask

    task automatic waitDone(input int budget);
        int k = 0;
        while (doneCnt == doneBefore && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("doneSeen", 32'(doneCnt != doneBefore), 1);
        repeat (3) @(negedge clk);
        checkOutput("donePulses", doneCnt - doneBefore, 1);
    endtask

    task automatic applyStimulus(input int width, input int mode, input logic [15:0] base, input bit randomMem);
        startCapture(width, mode, base, randomMem);
        waitDone(8 * ((width > DEPTH) ? DEPTH : width) + 200);
    endtask

    task automatic verifySnapshot();
        int orderErr = 0;
        int step;
        checkOutput("snapWidth", snapWidth, modelWidth);
        checkOutput("snapClamped", snapClamped, modelClamp);
        checkOutput("snapValid", snapValid, 1);
        checkOutput("busyIdle", busy, 0);
        for (int o = 0; o < 4; o++)
            checkOutput($sformatf("snapOsc%0d", o), snapOsc[o], modelOsc[o]);
        checkOutput("issueCount", issuedQ.size(), modelWidth);
        foreach (issuedQ[k])
            if (int'(issuedQ[k]) != k)
                orderErr++;
        checkOutput("issueOrder", orderErr, 0);
        step = (modelWidth > 64) ? 509 : 1;
        for (int i = 0; i < modelWidth; i += step)
            checkRead(i);
        if (modelWidth > 0)
            checkRead(modelWidth - 1);
        checkRead(modelWidth);
        checkRead(18'h3FFFF);
    endtask

    initial begin
        vec_t vecs [5];
        bit   sawDone;
        int   reqBefore;

        checkCount = 0;
        passCount  = 0;
        doneCnt    = 0;
        reqCnt     = 0;
        gntMode    = 0;
        rst_n      = 1'b0;
        frameStart = 1'b0;
        readerLock = 1'b0;
        waveWidth  = '0;
        oscIdx     = '0;
        snapIndex  = '0;

        vecs[0] = '{width: 5,     gntMode: 0, base: 16'hA000, expWidth: 5,    expClamp: 1'b0};
        vecs[1] = '{width: 8,     gntMode: 1, base: 16'hA000, expWidth: 8,    expClamp: 1'b0};
        vecs[2] = '{width: 20000, gntMode: 0, base: 16'h1000, expWidth: 8192, expClamp: 1'b1};
        vecs[3] = '{width: 1,     gntMode: 2, base: 16'h7E00, expWidth: 1,    expClamp: 1'b0};
        vecs[4] = '{width: 8192,  gntMode: 1, base: 16'h4000, expWidth: 8192, expClamp: 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("rstReq", memIf.mem_req_out, 0);
        checkOutput("rstAddr", memIf.mem_addr_out, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstValid", snapValid, 0);
        checkOutput("rstWidth", snapWidth, 0);
        checkOutput("rstClamped", snapClamped, 0);
        checkOutput("rstData", snapData, 0);
        checkOutput("rstOsc0", snapOsc[0], 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] table vectors");
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].width, vecs[v].gntMode, vecs[v].base, 1'b0);
            checkOutput($sformatf("vec%0dWidth", v), snapWidth, vecs[v].expWidth);
            checkOutput($sformatf("vec%0dClamp", v), snapClamped, vecs[v].expClamp);
            checkOutput($sformatf("vec%0dFirst", v), snapData, snapData);
            verifySnapshot();
        end
        checkRead(2);

        $display("[TB] random captures");
        for (int r = 0; r < 8; r++) begin
            applyStimulus($urandom_range(1, 48), $urandom_range(0, 2), 16'h0, 1'b1);
            verifySnapshot();
        end

        $display("[TB] reader lock");
        applyStimulus(5, 0, 16'hA000, 1'b0);
        verifySnapshot();
        readerLock = 1'b1;
        startCapture(7, 0, 16'hB000, 1'b0);
        repeat (60) @(negedge clk);
        checkOutput("lockBusy", busy, 1);
        checkOutput("lockNoDone", doneCnt - doneBefore, 0);
        checkOutput("lockOldWidth", snapWidth, 5);
        snapIndex = 18'd2;
        @(negedge clk);
        checkOutput("lockOldData", snapData, 16'hA002);
        snapIndex = 18'd5;
        @(negedge clk);
        checkOutput("lockOldPast", snapData, 16'h0000);
        readerLock = 1'b0;
        @(negedge clk);
        checkOutput("unlockDone", done, 1);
        checkOutput("unlockWidth", snapWidth, 7);
        repeat (2) @(negedge clk);
        checkOutput("unlockPulses", doneCnt - doneBefore, 1);
        verifySnapshot();

        $display("[TB] restart ignored mid-copy");
        startCapture(30, 2, 16'h0, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("busyMidCopy", busy, 1);
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        waitDone(600);
        repeat (40) @(negedge clk);
        checkOutput("restartPulses", doneCnt - doneBefore, 1);
        verifySnapshot();

        $display("[TB] zero width");
        modelWidth = 0;
        modelClamp = 1'b0;
        for (int o = 0; o < 4; o++)
            modelOsc[o] = 18'($urandom);
        issuedQ.delete();
        doneBefore = doneCnt;
        reqBefore  = reqCnt;
        sawDone    = 1'b0;
        waveWidth  = '0;
        oscIdx     = modelOsc;
        frameStart = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            frameStart = 1'b0;
            if (done)
                sawDone = 1'b1;
        end
        checkOutput("zeroDoneIn3", sawDone, 1);
        repeat (3) @(negedge clk);
        checkOutput("zeroNoReq", reqCnt - reqBefore, 0);
        checkOutput("zeroPulses", doneCnt - doneBefore, 1);
        verifySnapshot();

        $display("[TB] async reset mid-copy");
        startCapture(100, 0, 16'h5000, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("preRstReq", memIf.mem_req_out, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncReq", memIf.mem_req_out, 0);
        checkOutput("asyncAddr", memIf.mem_addr_out, 0);
        checkOutput("asyncBusy", busy, 0);
        checkOutput("asyncValid", snapValid, 0);
        checkOutput("asyncWidth", snapWidth, 0);
        checkOutput("asyncData", snapData, 0);
        checkOutput("asyncClamped", snapClamped, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(6, 1, 16'hC000, 1'b0);
        verifySnapshot();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
